insn_line_cache: RTL and testbench

Direct-mapped instruction line cache sitting between the CPU fetch stage and the bus master's instruction port. It accepts 32-bit word fetches at word addresses and serves hits from local storage. Misses are refilled as 128-bit lines through the bus master's insn_start/insn_addr/insn_ready/insn_data_rd handshake. One outstanding miss at a time.

---
 rtl/insn_line_cache.sv | 149 ++++++++++++++
 tb/tb_insn_line_cache.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/insn_line_cache.sv
// Direct-mapped instruction line cache: 32-bit word fetches, 128-bit line refills
// over the insn_* bus handshake. Define INSN_CACHE_STATS_EN to add hit/miss counters.
module insn_line_cache #(
  parameter int LINES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetch_start,
  input  logic [29:0]  fetch_addr,
  output logic         fetch_ready,
  output logic [31:0]  fetch_data,
  input  logic         flush,
  output logic         insn_start,
  output logic [27:0]  insn_addr,
  input  logic         insn_ready,
  input  logic [127:0] insn_data_rd
`ifdef INSN_CACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FILL
  } state_t;

  state_t             state;
  logic [127:0]       data_q [LINES];
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [LINES-1:0]   valid_q;
  logic [29:0]        addr_q;
  logic               flushed_q;

  logic [IDX_W-1:0]   look_idx;
  logic [TAG_W-1:0]   look_tag;
  logic               look_hit;
  logic [31:0]        look_word;
  logic               accept;

  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic [31:0]        fill_word;
  logic               fill_done;

  // A flush in the lookup cycle wins: the lookup must see every line invalid.
  assign look_idx  = fetch_addr[2 +: IDX_W];
  assign look_tag  = fetch_addr[29 -: TAG_W];
  assign look_hit  = valid_q[look_idx] && !flush && (tag_q[look_idx] == look_tag);
  assign look_word = data_q[look_idx][{fetch_addr[1:0], 5'd0} +: 32];
  assign accept    = (state == S_IDLE) && fetch_start;

  assign fill_idx  = addr_q[2 +: IDX_W];
  assign fill_tag  = addr_q[29 -: TAG_W];
  assign fill_word = insn_data_rd[{addr_q[1:0], 5'd0} +: 32];
  assign fill_done = (state == S_FILL) && insn_ready;

  // NOTE: line data and tags carry no reset; valid_q alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_q[fill_idx] <= insn_data_rd;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (flush) begin
        valid_q <= '0;
      end
      // A flush seen at any point of the miss leaves the refilled line invalid.
      if (fill_done && !flush && !flushed_q) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      fetch_ready <= 1'b0;
      fetch_data  <= '0;
      insn_start  <= 1'b0;
      insn_addr   <= '0;
      addr_q      <= '0;
      flushed_q   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle so they can never stretch past one clock.
      fetch_ready <= 1'b0;
      insn_start  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fetch_start) begin
            if (look_hit) begin
              fetch_ready <= 1'b1;
              fetch_data  <= look_word;
            end else begin
              addr_q     <= fetch_addr;
              insn_start <= 1'b1;
              insn_addr  <= fetch_addr[29:2];
              flushed_q  <= 1'b0;
              state      <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (flush) begin
            flushed_q <= 1'b1;
          end
          state <= S_FILL;
        end
        S_FILL: begin
          if (flush) begin
            flushed_q <= 1'b1;
          end
          if (insn_ready) begin
            fetch_ready <= 1'b1;
            fetch_data  <= fill_word;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef INSN_CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      if (look_hit) begin
        hit_count <= hit_count + 32'd1;
      end else begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_insn_line_cache.sv
// Directed self-checking bench for insn_line_cache (LINES = 16); the hit/miss
// counter checks are compiled only when INSN_CACHE_STATS_EN is defined.
module tb_insn_line_cache;

  logic         clk;
  logic         rst_n;
  logic         fetch_start;
  logic [29:0]  fetch_addr;
  logic         fetch_ready;
  logic [31:0]  fetch_data;
  logic         flush;
  logic         insn_start;
  logic [27:0]  insn_addr;
  logic         insn_ready;
  logic [127:0] insn_data_rd;
`ifdef INSN_CACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  insn_line_cache #(.LINES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_start  (fetch_start),
    .fetch_addr   (fetch_addr),
    .fetch_ready  (fetch_ready),
    .fetch_data   (fetch_data),
    .flush        (flush),
    .insn_start   (insn_start),
    .insn_addr    (insn_addr),
    .insn_ready   (insn_ready),
    .insn_data_rd (insn_data_rd)
`ifdef INSN_CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] LINE_1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] LINE_A = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
  localparam logic [127:0] LINE_B = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
  localparam logic [127:0] LINE_C = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
  localparam logic [127:0] LINE_D = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};

  // Inputs are driven and outputs sampled on the falling edge, away from the active edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Miss sequence: the bus answers lat cycles after the insn_start cycle, so
  // fetch_ready appears lat+2 cycles after the fetch_start cycle.
  task automatic do_miss(input logic [29:0] addr, input logic [127:0] line, input int lat,
                         input logic [31:0] exp_word, input logic [27:0] exp_line,
                         input bit flush_mid, input bit flush_start);
    fetch_start = 1'b1;
    fetch_addr  = addr;
    flush       = flush_start;
    step();
    fetch_start = 1'b0;
    flush       = 1'b0;
    check("miss_insn_start", {31'd0, insn_start}, 32'd1);
    check("miss_insn_addr", {4'd0, insn_addr}, {4'd0, exp_line});
    check("miss_no_ready", {31'd0, fetch_ready}, 32'd0);
    for (int i = 0; i < lat - 1; i++) begin
      step();
      flush = (i == 0) && flush_mid;
      check("miss_start_pulse", {31'd0, insn_start}, 32'd0);
      check("miss_addr_held", {4'd0, insn_addr}, {4'd0, exp_line});
      check("miss_wait_no_ready", {31'd0, fetch_ready}, 32'd0);
    end
    step();
    flush        = 1'b0;
    insn_ready   = 1'b1;
    insn_data_rd = line;
    step();
    insn_ready   = 1'b0;
    insn_data_rd = '0;
    check("miss_ready", {31'd0, fetch_ready}, 32'd1);
    check("miss_data", fetch_data, exp_word);
    step();
    check("miss_ready_pulse", {31'd0, fetch_ready}, 32'd0);
  endtask

  task automatic do_hit(input logic [29:0] addr, input logic [31:0] exp_word);
    fetch_start = 1'b1;
    fetch_addr  = addr;
    step();
    fetch_start = 1'b0;
    check("hit_ready", {31'd0, fetch_ready}, 32'd1);
    check("hit_data", fetch_data, exp_word);
    check("hit_no_start", {31'd0, insn_start}, 32'd0);
    step();
    check("hit_ready_pulse", {31'd0, fetch_ready}, 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    fetch_start  = 1'b0;
    fetch_addr   = '0;
    flush        = 1'b0;
    insn_ready   = 1'b0;
    insn_data_rd = '0;
    step();
    step();
    check("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
    check("rst_fetch_data", fetch_data, 32'd0);
    check("rst_insn_start", {31'd0, insn_start}, 32'd0);
    check("rst_insn_addr", {4'd0, insn_addr}, 32'd0);
`ifdef INSN_CACHE_STATS_EN
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Cold miss, bus latency 3 -> fetch_ready 5 cycles after fetch_start.
    do_miss(30'h0000010, LINE_1, 3, 32'h11111111, 28'h0000004, 1'b0, 1'b0);

    // Back-to-back hits on the same line: one word per cycle.
    fetch_start = 1'b1;
    fetch_addr  = 30'h0000011;
    step();
    check("b2b_ready_1", {31'd0, fetch_ready}, 32'd1);
    check("b2b_data_1", fetch_data, 32'h22222222);
    fetch_addr = 30'h0000012;
    step();
    check("b2b_ready_2", {31'd0, fetch_ready}, 32'd1);
    check("b2b_data_2", fetch_data, 32'h33333333);
    check("b2b_no_start_2", {31'd0, insn_start}, 32'd0);
    fetch_addr = 30'h0000013;
    step();
    fetch_start = 1'b0;
    check("b2b_ready_3", {31'd0, fetch_ready}, 32'd1);
    check("b2b_data_3", fetch_data, 32'h44444444);
    check("b2b_no_start_3", {31'd0, insn_start}, 32'd0);
    step();
    check("b2b_idle", {31'd0, fetch_ready}, 32'd0);

    // Same index, different tag: each access evicts the other.
    do_miss(30'h0000000, LINE_A, 2, 32'hA0A0A0A0, 28'h0000000, 1'b0, 1'b0);
    do_miss(30'h0000040, LINE_B, 1, 32'hB0B0B0B0, 28'h0000010, 1'b0, 1'b0);
    do_miss(30'h0000000, LINE_A, 4, 32'hA0A0A0A0, 28'h0000000, 1'b0, 1'b0);
    do_hit(30'h0000003, 32'hA3A3A3A3);

    // insn_ready while idle is ignored.
    insn_ready   = 1'b1;
    insn_data_rd = LINE_D;
    step();
    insn_ready   = 1'b0;
    insn_data_rd = '0;
    check("stray_ready_ignored", {31'd0, fetch_ready}, 32'd0);
    step();

    // Flush during FILL: data returned, line left invalid; other lines flushed too.
    do_miss(30'h0000020, LINE_C, 3, 32'hC0C0C0C0, 28'h0000008, 1'b1, 1'b0);
    do_miss(30'h0000022, LINE_C, 2, 32'hC2C2C2C2, 28'h0000008, 1'b0, 1'b0);
    do_miss(30'h0000010, LINE_1, 1, 32'h11111111, 28'h0000004, 1'b0, 1'b0);

    // Flush together with fetch_start: the lookup misses on a line that was valid.
    do_hit(30'h0000021, 32'hC1C1C1C1);
    do_miss(30'h0000021, LINE_C, 2, 32'hC1C1C1C1, 28'h0000008, 1'b0, 1'b1);
    do_hit(30'h0000023, 32'hC3C3C3C3);

    // Reset during FILL, then a late bus response: nothing is returned.
    fetch_start = 1'b1;
    fetch_addr  = 30'h0000030;
    step();
    fetch_start = 1'b0;
    check("rstmid_insn_start", {31'd0, insn_start}, 32'd1);
    check("rstmid_insn_addr", {4'd0, insn_addr}, 32'h0000000C);
    step();
    rst_n = 1'b0;
    step();
    check("rstmid_no_ready", {31'd0, fetch_ready}, 32'd0);
    check("rstmid_insn_addr_clr", {4'd0, insn_addr}, 32'd0);
    rst_n = 1'b1;
    step();
    insn_ready   = 1'b1;
    insn_data_rd = LINE_D;
    step();
    insn_ready   = 1'b0;
    insn_data_rd = '0;
    check("rstmid_late_resp_dropped", {31'd0, fetch_ready}, 32'd0);
    step();
    check("rstmid_still_no_ready", {31'd0, fetch_ready}, 32'd0);
`ifdef INSN_CACHE_STATS_EN
    check("stats_clr_hit", hit_count, 32'd0);
    check("stats_clr_miss", miss_count, 32'd0);
`endif

    // Same address misses after reset; then three hits on that line.
    do_miss(30'h0000030, LINE_D, 2, 32'hD0D0D0D0, 28'h000000C, 1'b0, 1'b0);
    do_hit(30'h0000031, 32'hD1D1D1D1);
    do_hit(30'h0000032, 32'hD2D2D2D2);
    do_hit(30'h0000033, 32'hD3D3D3D3);
`ifdef INSN_CACHE_STATS_EN
    check("stats_hit_count", hit_count, 32'd3);
    check("stats_miss_count", miss_count, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
